// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding and constants for the CPU run/step controller
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_STEP     = 2'd2,
    ST_RST_HOLD = 2'd3
  } run_state_t;

  // Number of cycles the CPU reset is held low after a restart request
  localparam int RST_HOLD_CYCLES = 16;

  // Fast-run tick period is the slow period divided by 2^FAST_SHIFT
  localparam int FAST_SHIFT = 4;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - board switch inputs and CPU control outputs of the run/step controller
interface cpu_run_ctrl_if;

  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_Cpu_Ce;
  logic       o_Cpu_Rst_n;
  logic       o_Running;
  logic [7:0] o_Step_Count;

  // Controller side: consumes switches, produces CPU controls
  modport master (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_Cpu_Ce, o_Cpu_Rst_n, o_Running, o_Step_Count
  );

  // Board/CPU side: drives switches, observes CPU controls
  modport slave (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_Cpu_Ce, o_Cpu_Rst_n, o_Running, o_Step_Count
  );

endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 2-FF synchronizer, counting debouncer and rising-edge press pulse
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Bring the asynchronous switch into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has persisted for DEBOUNCE_CYCLES; any return clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle pulse on each rising edge of the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/step/restart controller producing CPU clock enable and reset
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV_LOG2   = 22
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  cpu_run_ctrl_if.master bus
);

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic sw1_press, sw2_press, sw4_press, sw3_level;
  logic sw1_level_unused, sw2_level_unused, sw4_level_unused, sw3_press_unused;

  logic [TICK_DIV_LOG2-1:0] presc;
  logic                     tick;
  logic [HOLD_W-1:0]        hold_cnt;
  run_state_t               state, state_next;
  logic                     ce_next;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .clk(i_Clk), .rst_n(i_Rst_n), .raw(bus.i_Switch_1),
    .level(sw1_level_unused), .press(sw1_press)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
    .clk(i_Clk), .rst_n(i_Rst_n), .raw(bus.i_Switch_2),
    .level(sw2_level_unused), .press(sw2_press)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw3 (
    .clk(i_Clk), .rst_n(i_Rst_n), .raw(bus.i_Switch_3),
    .level(sw3_level), .press(sw3_press_unused)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw4 (
    .clk(i_Clk), .rst_n(i_Rst_n), .raw(bus.i_Switch_4),
    .level(sw4_level_unused), .press(sw4_press)
  );

  // Free-running prescaler; speed changes only reselect which tick is used
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) presc <= '0;
    else          presc <= presc + 1'b1;
  end

  assign tick = sw3_level ? (&presc[TICK_DIV_LOG2-FAST_SHIFT-1:0]) : (&presc);

  // Next state and next clock enable; restart outranks run/halt, which outranks step
  always_comb begin
    state_next = state;
    ce_next    = 1'b0;
    case (state)
      ST_RUN:      if (sw1_press) state_next = ST_HALT;
      ST_HALT: begin
        if (sw1_press)      state_next = ST_RUN;
        else if (sw2_press) state_next = ST_STEP;
      end
      ST_STEP:     state_next = ST_HALT;
      ST_RST_HOLD: if (hold_cnt == HOLD_LAST) state_next = ST_HALT;
      default:     state_next = ST_RUN;
    endcase
    if (sw4_press) state_next = ST_RST_HOLD;
    // A tick on the cycle RUN is left does not produce an enable
    ce_next = (state == ST_RUN && state_next == ST_RUN && tick) || (state_next == ST_STEP);
  end

  // State register with registered outputs aligned to it
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state            <= ST_RUN;
      hold_cnt         <= '0;
      bus.o_Cpu_Ce     <= 1'b0;
      bus.o_Cpu_Rst_n  <= 1'b1;
      bus.o_Running    <= 1'b1;
      bus.o_Step_Count <= 8'd0;
    end else begin
      state           <= state_next;
      hold_cnt        <= (state == ST_RST_HOLD && !sw4_press) ? hold_cnt + 1'b1 : '0;
      bus.o_Cpu_Ce    <= ce_next;
      bus.o_Cpu_Rst_n <= (state_next != ST_RST_HOLD);
      bus.o_Running   <= (state_next == ST_RUN);
      if (state_next == ST_RST_HOLD) bus.o_Step_Count <= 8'd0;
      else if (ce_next)              bus.o_Step_Count <= bus.o_Step_Count + 8'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV_LOG2(6)) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic measure(input int n, output int pulses, output int first, output int gap);
    int last;
    pulses = 0;
    first  = -1;
    gap    = -1;
    last   = -1;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (bus.o_Cpu_Ce === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        else if (gap < 0) gap = i - last;
        last = i;
      end
    end
  endtask

  initial begin
    int p, f, g, tot;
    int lowc, ce_low, cnt_bad, first_low;
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    bus.i_Switch_3 = 1'b0;
    bus.i_Switch_4 = 1'b0;
    rst_n = 1'b0;
    step(3);
    check_eq("rst_running", bus.o_Running, 1);
    check_eq("rst_ce", bus.o_Cpu_Ce, 0);
    check_eq("rst_cpu_rst_n", bus.o_Cpu_Rst_n, 1);
    check_eq("rst_count", bus.o_Step_Count, 0);

    // Free run at slow rate from reset release
    rst_n = 1'b1;
    measure(200, p, f, g);
    check_eq("slow_pulses", p, 3);
    check_eq("slow_first", f, 64);
    check_eq("slow_gap", g, 64);
    check_eq("slow_count", bus.o_Step_Count, 3);

    // Speed select
    bus.i_Switch_3 = 1'b1;
    step(10);
    measure(40, p, f, g);
    check_eq("fast_pulses", p, 10);
    check_eq("fast_gap", g, 4);
    bus.i_Switch_3 = 1'b0;
    step(10);
    measure(128, p, f, g);
    check_eq("slow_again_pulses", p, 2);
    check_eq("slow_again_gap", g, 64);

    // Restart from RUN
    bus.i_Switch_4 = 1'b1;
    lowc = 0; ce_low = 0; cnt_bad = 0; first_low = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (i == 10) bus.i_Switch_4 = 1'b0;
      if (bus.o_Cpu_Rst_n !== 1'b1) begin
        lowc++;
        if (first_low < 0) first_low = i;
        if (bus.o_Cpu_Ce !== 1'b0) ce_low++;
        if (bus.o_Step_Count !== 8'd0) cnt_bad++;
      end
    end
    check_eq("restart_latency", first_low, 8);
    check_eq("restart_low_cycles", lowc, 16);
    check_eq("restart_ce_during", ce_low, 0);
    check_eq("restart_count_during", cnt_bad, 0);
    check_eq("restart_halt", bus.o_Running, 0);
    check_eq("restart_rst_released", bus.o_Cpu_Rst_n, 1);
    check_eq("restart_count", bus.o_Step_Count, 0);

    // Long hold of sw2 in HALT gives one step
    bus.i_Switch_2 = 1'b1;
    measure(1000, p, f, g);
    bus.i_Switch_2 = 1'b0;
    step(10);
    check_eq("hold_step_pulses", p, 1);
    check_eq("hold_step_count", bus.o_Step_Count, 1);
    check_eq("hold_step_halted", bus.o_Running, 0);

    // 255 more steps wrap the count back to zero
    tot = 0;
    for (int k = 0; k < 255; k++) begin
      bus.i_Switch_2 = 1'b1;
      measure(8, p, f, g);
      tot += p;
      bus.i_Switch_2 = 1'b0;
      measure(8, p, f, g);
      tot += p;
      if (k == 253) check_eq("count_255", bus.o_Step_Count, 255);
    end
    check_eq("wrap_pulses", tot, 255);
    check_eq("wrap_count", bus.o_Step_Count, 0);

    // Simultaneous sw1+sw2 in HALT resumes RUN
    bus.i_Switch_1 = 1'b1;
    bus.i_Switch_2 = 1'b1;
    step(8);
    bus.i_Switch_1 = 1'b0;
    bus.i_Switch_2 = 1'b0;
    step(6);
    check_eq("sw1_sw2_run", bus.o_Running, 1);

    // Short glitches on sw1 are rejected
    for (int k = 0; k < 3; k++) begin
      bus.i_Switch_1 = 1'b1;
      step(3);
      bus.i_Switch_1 = 1'b0;
      step(5);
      check_eq("glitch_running", bus.o_Running, 1);
    end

    // A real sw1 press halts after the full latency
    bus.i_Switch_1 = 1'b1;
    step(7);
    check_eq("halt_not_yet", bus.o_Running, 1);
    step(1);
    check_eq("halt_now", bus.o_Running, 0);
    check_eq("halt_leave_ce", bus.o_Cpu_Ce, 0);
    step(2);
    bus.i_Switch_1 = 1'b0;
    measure(200, p, f, g);
    check_eq("halt_no_ce", p, 0);

    // Asynchronous reset in the middle of RST_HOLD
    bus.i_Switch_4 = 1'b1;
    step(8);
    bus.i_Switch_4 = 1'b0;
    step(4);
    check_eq("hold_entered", bus.o_Cpu_Rst_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_running", bus.o_Running, 1);
    check_eq("async_cpu_rst_n", bus.o_Cpu_Rst_n, 1);
    check_eq("async_ce", bus.o_Cpu_Ce, 0);
    check_eq("async_count", bus.o_Step_Count, 0);
    rst_n = 1'b1;
    measure(100, p, f, g);
    check_eq("post_reset_pulses", p, 1);
    check_eq("post_reset_first", f, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
